i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target: 7-bit address, byte register pointer, write strobes and
// read fetch from fabric registers over an open-drain SDA.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h0A
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
    } state_t;

    state_t     state;
    logic       scl_s1, scl_s2, scl_q;
    logic       sda_s1, sda_s2, sda_q;
    logic [3:0] cnt;
    logic [7:0] rx, tx, ptr;
    logic       rw, ack_n;
    logic       scl_rise, scl_fall, start_c, stop_c;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_q  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_q  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_q  <= sda_s2;
        end
    end

    // SDA edges count as START/STOP only with SCL steadily high
    assign scl_rise = scl_s2 & ~scl_q;
    assign scl_fall = ~scl_s2 & scl_q;
    assign start_c  = scl_s2 & scl_q & sda_q & ~sda_s2;
    assign stop_c   = scl_s2 & scl_q & ~sda_q & sda_s2;
    assign rd_addr  = ptr;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            busy      <= 1'b0;
            cnt       <= 4'd0;
            rx        <= 8'h00;
            tx        <= 8'h00;
            ptr       <= 8'h00;
            rw        <= 1'b0;
            ack_n     <= 1'b1;
        end else begin
            wr_strobe <= 1'b0;
            if (start_c) begin
                state  <= ADDR;
                cnt    <= 4'd0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (stop_c) begin
                state  <= IDLE;
                cnt    <= 4'd0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (scl_rise) begin
                unique case (state)
                    ADDR, PTR: begin
                        rx  <= {rx[6:0], sda_s2};
                        cnt <= cnt + 4'd1;
                    end
                    WDATA: begin
                        rx  <= {rx[6:0], sda_s2};
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= {rx[6:0], sda_s2};
                            ptr       <= ptr + 8'd1;
                        end
                    end
                    RDATA:     cnt   <= cnt + 4'd1;
                    RDATA_ACK: ack_n <= sda_s2;
                    default: ;
                endcase
            end else if (scl_fall) begin
                unique case (state)
                    ADDR: begin
                        if (cnt == 4'd8) begin
                            if (rx[7:1] == DEV_ADDR) begin
                                state  <= ADDR_ACK;
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= rx[0];
                            end else begin
                                state  <= WAIT;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        cnt <= 4'd0;
                        if (rw) begin
                            state  <= RDATA;
                            tx     <= rd_data;
                            ptr    <= ptr + 8'd1;
                            sda_oe <= ~rd_data[7];
                        end else begin
                            state  <= PTR;
                            sda_oe <= 1'b0;
                        end
                    end
                    PTR: begin
                        if (cnt == 4'd8) begin
                            ptr    <= rx;
                            state  <= PTR_ACK;
                            sda_oe <= 1'b1;
                        end
                    end
                    WDATA: begin
                        if (cnt == 4'd8) begin
                            state  <= WDATA_ACK;
                            sda_oe <= 1'b1;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        state  <= WDATA;
                        sda_oe <= 1'b0;
                        cnt    <= 4'd0;
                    end
                    RDATA: begin
                        if (cnt == 4'd8) begin
                            state  <= RDATA_ACK;
                            sda_oe <= 1'b0;
                        end else if (cnt != 4'd0) begin
                            tx     <= {tx[6:0], 1'b0};
                            sda_oe <= ~tx[6];
                        end
                    end
                    RDATA_ACK: begin
                        cnt <= 4'd0;
                        if (!ack_n) begin
                            state  <= RDATA;
                            tx     <= rd_data;
                            ptr    <= ptr + 8'd1;
                            sda_oe <= ~rd_data[7];
                        end else begin
                            state  <= WAIT;
                            sda_oe <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
